dmem_responder: RTL
===================

// Module: dmem_responder
// PURPOSE
//   Responder (memory side) for the MEM-stage data-memory interface of the pipelined MIPS core:
//   mem_read / mem_write / address / data_in in, data_out out.
//   Replaces the zero-latency stub with a multi-cycle word memory. Adds mem_ready so the core
//   can stall MEM until each access completes, and mem_err for illegal accesses.
//   Sits between the EX/MEM pipeline register outputs and the MEM/WB register inputs.
// PARAMETERS
//   DEPTH_LOG2   8        log2 of storage depth in 32-bit words (256 words)
//   WAIT_CYCLES  2        extra wait states per access; 0 is legal
//   BASE_ADDR    32'h0    byte address of word 0
// PORTS
//   clk        in   1   clock; all state updates on posedge
//   reset      in   1   synchronous, active-low reset (asserted when 0, sampled at posedge clk)
//   mem_read   in   1   read request; held by initiator until mem_ready
//   mem_write  in   1   write request; held by initiator until mem_ready
//   address    in   32  byte address, word aligned
//   data_in    in   32  write data
//   data_out   out  32  read data, valid while mem_ready and !mem_err on a read
//   mem_ready  out  1   one-cycle completion pulse
//   mem_err    out  1   error flag, qualified by mem_ready
// BEHAVIOUR
//   - Reset (reset==0 at posedge): state=IDLE, wait count=0, data_out=0, mem_ready=0, mem_err=0.
//     Storage contents are NOT cleared. A request in flight is abandoned; a pending write is
//     never committed.
//   - FSM IDLE -> BUSY -> RESP -> IDLE. All outputs are registered.
//   - IDLE: if (mem_read|mem_write) at edge N, latch op, address and data_in. Set cnt=WAIT_CYCLES
//     and go to BUSY. With no request, stay in IDLE.
//   - BUSY: if cnt!=0 then cnt<=cnt-1; else go to RESP at the next edge. Input changes during
//     BUSY/RESP are ignored; only latched values are used.
//   - Entering RESP (edge N+1+WAIT_CYCLES):
//       - Commit a legal write to the array.
//       - For a legal read, load data_out with the array word.
//       - Set mem_ready=1. mem_err=1 if the access is illegal.
//   - RESP lasts exactly one cycle; then IDLE with mem_ready=0.
//   - Request still asserted in the IDLE cycle after RESP is a NEW request.
//     Minimum spacing: accept to accept = WAIT_CYCLES+3 edges.
//   - Legality:
//       - off = address - BASE_ADDR (32-bit wrap).
//       - Illegal if off[1:0]!=0, or off >= 4<<DEPTH_LOG2, or mem_read&mem_write both set.
//       - Index = off[DEPTH_LOG2+1:2].
//   - Illegal access: no array write; data_out<=0; mem_err=1 with mem_ready.
//   - Legal write: data_out keeps its previous value; mem_err=0.
//   - Read-after-write to the same word, issued after the write's RESP, returns the new data.
//   - BASE_ADDR+(4<<DEPTH_LOG2)-4 is the last legal word. BASE_ADDR-4 wraps to a large off
//     and is therefore illegal.
// STRUCTURE
//   - Shared header dmem_defs.v holds the state encodings (IDLE=2'd0, BUSY=2'd1, RESP=2'd2)
//     and the wait-counter width macro. Counter width is clog2(WAIT_CYCLES+1), minimum 1.
//   - Sub-module dmem_array: 2^DEPTH_LOG2 x 32 storage, synchronous write
//     (we, waddr, wdata), combinational read (raddr -> rdata).
//   - The top module contains only the FSM, latches, decode and output registers.
// TESTING  (defaults unless stated)
//   1. Write 0xDEADBEEF @0x10, then read @0x10:
//      - mem_ready rises 3 edges after each accept.
//      - The read returns data_out=0xDEADBEEF with mem_err=0.
//   2. WAIT_CYCLES=0 build, back-to-back held request: mem_ready pulses every 3 cycles.
//      The request is re-accepted in the IDLE cycle.
//   3. Read @0x12 (misaligned) and read @0x400 (out of range):
//      - Both give mem_ready=1, mem_err=1, data_out=0.
//      - The array is unchanged.
//   4. mem_read=mem_write=1 @0x20 with data_in=0x1: mem_err=1, and a later read @0x20 returns
//      the prior value.
//   5. Write 0x55 @0x3FC, toggle address/data_in during BUSY, then read @0x3FC:
//      returns 0x55 (latched inputs used, last word legal).
//   6. Write 0xAA @0x8, drive reset=0 in BUSY:
//      - Outputs go to 0 the next edge.
//      - A read @0x8 after reset returns the old contents (not 0xAA).

Source files
------------

// File: rtl/dmem_responder_pkg.sv
// Shared types for the data-memory responder: FSM state encoding and the
// wait-counter width helper.
package dmem_responder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    // Width needed to hold WAIT_CYCLES, never narrower than one bit.
    function automatic int cnt_width(input int unsigned wait_cycles);
        int w;
        w = $clog2(wait_cycles + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/dmem_responder_array.sv
// Word storage for the data-memory responder: synchronous write port,
// combinational read port, contents never cleared by reset.
module dmem_responder_array #(
    parameter int unsigned DEPTH_LOG2 = 8
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [DEPTH_LOG2-1:0] waddr,
    input  logic [31:0]           wdata,
    input  logic [DEPTH_LOG2-1:0] raddr,
    output logic [31:0]           rdata
);

    logic [31:0] mem_q [2**DEPTH_LOG2];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder for the MEM stage: latches one request,
// waits WAIT_CYCLES, then answers with a one-cycle mem_ready pulse.
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int unsigned DEPTH_LOG2  = 8,
    parameter int unsigned WAIT_CYCLES = 2,
    parameter logic [31:0] BASE_ADDR   = 32'h0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [31:0] address,
    input  logic [31:0] data_in,
    output logic [31:0] data_out,
    output logic        mem_ready,
    output logic        mem_err,
    output state_e      dbg_state
);

    // Handshake: the initiator holds mem_read/mem_write (plus address and
    // data_in) until it sees mem_ready; mem_ready is a single-cycle pulse and
    // mem_err/data_out are meaningful only in that cycle. A request still held
    // in the IDLE cycle after the pulse is taken as a fresh request.

    localparam int CW = cnt_width(WAIT_CYCLES);

    state_e              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic                is_read_q, is_read_d;
    logic                is_write_q, is_write_d;
    logic [31:0]         addr_q, addr_d;
    logic [31:0]         wdata_q, wdata_d;
    logic [31:0]         data_out_q, data_out_d;
    logic                ready_q, ready_d;
    logic                err_q, err_d;

    logic [31:0]           off;
    logic                  illegal;
    logic [DEPTH_LOG2-1:0] idx;
    logic                  finishing;
    logic                  arr_we;
    logic [31:0]           arr_rdata;

    // Offset wraps at 32 bits, so addresses below BASE_ADDR land far out of range.
    assign off     = addr_q - BASE_ADDR;
    assign idx     = off[DEPTH_LOG2+1:2];
    assign illegal = (|off[1:0]) | (|off[31:DEPTH_LOG2+2]) | (is_read_q & is_write_q);

    assign finishing = (state_q == ST_BUSY) && (cnt_q == '0);
    // Gated by reset so a write caught by reset on its commit edge is dropped.
    assign arr_we    = reset & finishing & is_write_q & ~illegal;

    dmem_responder_array #(
        .DEPTH_LOG2(DEPTH_LOG2)
    ) u_array (
        .clk   (clk),
        .we    (arr_we),
        .waddr (idx),
        .wdata (wdata_q),
        .raddr (idx),
        .rdata (arr_rdata)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        is_read_d  = is_read_q;
        is_write_d = is_write_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        data_out_d = data_out_q;
        ready_d    = 1'b0;
        err_d      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (mem_read || mem_write) begin
                    is_read_d  = mem_read;
                    is_write_d = mem_write;
                    addr_d     = address;
                    wdata_d    = data_in;
                    cnt_d      = CW'(WAIT_CYCLES);
                    state_d    = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CW'(1);
                end else begin
                    state_d = ST_RESP;
                    ready_d = 1'b1;
                    err_d   = illegal;
                    if (illegal) begin
                        data_out_d = 32'h0;
                    end else if (is_read_q) begin
                        data_out_d = arr_rdata;
                    end
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            is_read_q  <= 1'b0;
            is_write_q <= 1'b0;
            addr_q     <= 32'h0;
            wdata_q    <= 32'h0;
            data_out_q <= 32'h0;
            ready_q    <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            is_read_q  <= is_read_d;
            is_write_q <= is_write_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            data_out_q <= data_out_d;
            ready_q    <= ready_d;
            err_q      <= err_d;
        end
    end

    assign data_out  = data_out_q;
    assign mem_ready = ready_q;
    assign mem_err   = err_q;
    assign dbg_state = state_q;

endmodule
